// File: rtl/key_tone_pkg.sv
// Shared types and note-table helpers for the key-to-tone arbiter.
// Half periods are computed at elaboration from CLK_HZ; nothing here becomes a runtime divider.
package key_tone_pkg;

    localparam int NUM_KEYS = 8;
    localparam int HP_W     = 18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_e;

    typedef logic [NUM_KEYS-1:0][HP_W-1:0] note_table_t;

    // Equal-temperament frequencies in micro-hertz (A4 = 440 Hz), rounded to nearest DCLK cycle.
    function automatic logic [HP_W-1:0] note_half_period(input logic [2:0] idx, input longint clk_hz);
        longint f_uhz;
        case (idx)
            3'd0:    f_uhz = 261625565;
            3'd1:    f_uhz = 293664768;
            3'd2:    f_uhz = 329627557;
            3'd3:    f_uhz = 349228231;
            3'd4:    f_uhz = 391995436;
            3'd5:    f_uhz = 440000000;
            3'd6:    f_uhz = 493883301;
            default: f_uhz = 523251131;
        endcase
        return HP_W'((clk_hz * 1000000 + f_uhz) / (2 * f_uhz));
    endfunction

    function automatic note_table_t note_table(input longint clk_hz);
        note_table_t t;
        for (int i = 0; i < NUM_KEYS; i++) begin
            t[i] = note_half_period(3'(i), clk_hz);
        end
        return t;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: two-flop synchroniser followed by a tick-sampled debounce counter.
module key_debounce #(
    parameter int DB_TICKS = 10
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tick_i,
    input  logic key_i,
    output logic state_o
);

    localparam int CNT_W = $clog2(DB_TICKS + 1);

    logic [1:0]       sync_q;
    logic             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            state_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], key_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The DB_TICKS-th differing sample toggles the state instead of being stored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (tick_i) begin
            if (sync_q[1] == state_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_W'(DB_TICKS - 1)) begin
                state_d = ~state_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/key_tone_arbiter.sv
// Debounces eight piano keys and grants the shared tone generator to one key at a time.
module key_tone_arbiter
    import key_tone_pkg::*;
#(
    parameter int          TICK_DIV  = 50000,
    parameter int          DB_TICKS  = 10,
    parameter int          GAP_TICKS = 20,
    parameter int unsigned CLK_HZ    = 50000000
) (
    input  logic                DCLK,
    input  logic                RSTN,
    input  logic [NUM_KEYS-1:0] KEY,
    input  logic                ENABLE,
    output logic [NUM_KEYS-1:0] KEY_STATE,
    output logic                NOTE_ON,
    output logic [2:0]          NOTE_IDX,
    output logic [HP_W-1:0]     HALF_PERIOD
);

    localparam int          PRE_W      = $clog2(TICK_DIV);
    localparam int          GAP_W      = $clog2(GAP_TICKS + 1);
    localparam note_table_t NOTE_TABLE = note_table(longint'(CLK_HZ));

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick;
    state_e           state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             note_on_q, note_on_d;
    logic [2:0]       note_idx_q, note_idx_d;
    logic [HP_W-1:0]  hp_q, hp_d;
    logic [2:0]       grant_idx;

    assign tick  = (pre_q == PRE_W'(TICK_DIV - 1));
    assign pre_d = tick ? '0 : pre_q + 1'b1;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(.DB_TICKS(DB_TICKS)) u_debounce (
            .clk_i   (DCLK),
            .rst_ni  (RSTN),
            .tick_i  (tick),
            .key_i   (KEY[k]),
            .state_o (KEY_STATE[k])
        );
    end

    // Lowest-index pressed key wins.
    always_comb begin
        grant_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (KEY_STATE[i]) grant_idx = 3'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        note_on_d  = note_on_q;
        note_idx_d = note_idx_q;
        hp_d       = hp_q;
        if (!ENABLE) begin
            state_d   = IDLE;
            note_on_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|KEY_STATE) begin
                        note_idx_d = grant_idx;
                        hp_d       = NOTE_TABLE[grant_idx];
                        note_on_d  = 1'b1;
                        state_d    = PLAY;
                    end
                end
                PLAY: begin
                    // No preemption: only the granted key's release matters here.
                    if (!KEY_STATE[note_idx_q]) begin
                        note_on_d = 1'b0;
                        gap_d     = '0;
                        state_d   = GAP;
                    end
                end
                GAP: begin
                    note_on_d = 1'b0;
                    if (tick) begin
                        gap_d = gap_q + 1'b1;
                        if (gap_q == GAP_W'(GAP_TICKS - 1)) state_d = IDLE;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    note_on_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge DCLK or negedge RSTN) begin
        if (!RSTN) begin
            pre_q      <= '0;
            state_q    <= IDLE;
            gap_q      <= '0;
            note_on_q  <= 1'b0;
            note_idx_q <= '0;
            hp_q       <= '0;
        end else begin
            pre_q      <= pre_d;
            state_q    <= state_d;
            gap_q      <= gap_d;
            note_on_q  <= note_on_d;
            note_idx_q <= note_idx_d;
            hp_q       <= hp_d;
        end
    end

    assign NOTE_ON     = note_on_q;
    assign NOTE_IDX    = note_idx_q;
    assign HALF_PERIOD = hp_q;

endmodule

// File: tb/tb_key_tone_arbiter.sv
// Directed bench for key_tone_arbiter with a short tick so debounce and gap timing are visible.
module tb_key_tone_arbiter;

    localparam int TICK_DIV  = 4;
    localparam int DB_TICKS  = 3;
    localparam int GAP_TICKS = 2;
    localparam int BUDGET    = 200;

    logic        DCLK = 1'b0;
    logic        RSTN;
    logic [7:0]  KEY;
    logic        ENABLE;
    logic [7:0]  KEY_STATE;
    logic        NOTE_ON;
    logic [2:0]  NOTE_IDX;
    logic [17:0] HALF_PERIOD;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    key_tone_arbiter #(
        .TICK_DIV  (TICK_DIV),
        .DB_TICKS  (DB_TICKS),
        .GAP_TICKS (GAP_TICKS)
    ) dut (
        .DCLK        (DCLK),
        .RSTN        (RSTN),
        .KEY         (KEY),
        .ENABLE      (ENABLE),
        .KEY_STATE   (KEY_STATE),
        .NOTE_ON     (NOTE_ON),
        .NOTE_IDX    (NOTE_IDX),
        .HALF_PERIOD (HALF_PERIOD)
    );

    always #5 DCLK = ~DCLK;

    // Rising edges since reset release; with TICK_DIV=4 the tick lands on edges 4, 8, 12, ...
    always @(posedge DCLK or negedge RSTN) begin
        if (!RSTN) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wait_note(input string tag, input logic lvl);
        int n = 0;
        while (NOTE_ON !== lvl && n < BUDGET) begin
            @(negedge DCLK);
            n++;
        end
        chk(tag, 32'(NOTE_ON), 32'(lvl));
    endtask

    task automatic wait_key(input string tag, input int b, input logic lvl, output int at);
        int n = 0;
        while (KEY_STATE[b] !== lvl && n < BUDGET) begin
            @(negedge DCLK);
            n++;
        end
        at = cyc;
        chk(tag, 32'(KEY_STATE[b]), 32'(lvl));
    endtask

    // Key changed before edge c+1: synced level reaches the debouncer at edge c+3,
    // then the third tick at or after that edge flips the debounced state.
    function automatic int exp_rise(input int c);
        int q = c + 3;
        while (q % TICK_DIV != 0) q++;
        return q + TICK_DIV * (DB_TICKS - 1);
    endfunction

    initial begin
        int c, at, fall, bad;
        RSTN   = 1'b0;
        KEY    = '0;
        ENABLE = 1'b1;
        repeat (3) @(negedge DCLK);
        chk("rst_key_state", 32'(KEY_STATE), 32'h0);
        chk("rst_note_on", 32'(NOTE_ON), 32'h0);
        chk("rst_note_idx", 32'(NOTE_IDX), 32'h0);
        chk("rst_half_period", 32'(HALF_PERIOD), 32'h0);
        RSTN = 1'b1;
        repeat (2) @(negedge DCLK);

        // Clean press on A4
        KEY[5] = 1'b1;
        c = cyc;
        wait_key("a4_debounce", 5, 1'b1, at);
        chk("a4_rise_edge", 32'(at), 32'(exp_rise(c)));
        chk("a4_key_state", 32'(KEY_STATE), 32'h20);
        chk("a4_latency", 32'(NOTE_ON), 32'h0);
        @(negedge DCLK);
        chk("a4_note_on", 32'(NOTE_ON), 32'h1);
        chk("a4_note_idx", 32'(NOTE_IDX), 32'd5);
        chk("a4_half_period", 32'(HALF_PERIOD), 32'd56818);

        // Asynchronous reset while playing
        #2 RSTN = 1'b0;
        #1;
        chk("arst_note_on", 32'(NOTE_ON), 32'h0);
        chk("arst_key_state", 32'(KEY_STATE), 32'h0);
        chk("arst_half_period", 32'(HALF_PERIOD), 32'h0);
        chk("arst_note_idx", 32'(NOTE_IDX), 32'h0);
        KEY = '0;
        repeat (3) @(negedge DCLK);
        RSTN = 1'b1;
        repeat (2) @(negedge DCLK);

        // Bouncing key 2 never settles, then a steady press
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            KEY[2] = ~KEY[2];
            repeat (5) begin
                @(negedge DCLK);
                if (KEY_STATE[2] !== 1'b0) bad = 1;
            end
        end
        chk("bounce_hold_low", 32'(bad), 32'h0);
        KEY[2] = 1'b1;
        c = cyc;
        wait_key("bounce_settle", 2, 1'b1, at);
        chk("bounce_rise_edge", 32'(at), 32'(exp_rise(c)));
        wait_note("e4_on", 1'b1);
        chk("e4_note_idx", 32'(NOTE_IDX), 32'd2);
        KEY[2] = 1'b0;
        wait_note("e4_off", 1'b0);
        repeat (30) @(negedge DCLK);

        // Simultaneous presses, then release of the granted key
        KEY[1] = 1'b1;
        KEY[6] = 1'b1;
        wait_note("dual_on", 1'b1);
        chk("dual_note_idx", 32'(NOTE_IDX), 32'd1);
        chk("dual_key_state", 32'(KEY_STATE), 32'h42);
        KEY[1] = 1'b0;
        wait_note("dual_release", 1'b0);
        fall = cyc;
        chk("gap_keeps_idx", 32'(NOTE_IDX), 32'd1);
        wait_note("dual_regrant", 1'b1);
        chk("gap_length", 32'(cyc - fall), 32'(GAP_TICKS * TICK_DIV));
        chk("regrant_idx", 32'(NOTE_IDX), 32'd6);
        KEY[6] = 1'b0;
        wait_note("b4_off", 1'b0);
        repeat (30) @(negedge DCLK);
        chk("all_released", 32'(KEY_STATE), 32'h0);

        // No preemption by a lower key, then re-articulation of the held key
        KEY[7] = 1'b1;
        wait_note("c5_on", 1'b1);
        chk("c5_note_idx", 32'(NOTE_IDX), 32'd7);
        chk("c5_half_period", 32'(HALF_PERIOD), 32'd47778);
        KEY[0] = 1'b1;
        wait_key("c4_debounce", 0, 1'b1, at);
        repeat (3) @(negedge DCLK);
        chk("nopre_note_on", 32'(NOTE_ON), 32'h1);
        chk("nopre_note_idx", 32'(NOTE_IDX), 32'd7);
        chk("nopre_half_period", 32'(HALF_PERIOD), 32'd47778);
        KEY[7] = 1'b0;
        wait_note("c5_off", 1'b0);
        wait_note("c4_on", 1'b1);
        chk("c4_note_idx", 32'(NOTE_IDX), 32'd0);
        chk("c4_half_period", 32'(HALF_PERIOD), 32'd95556);
        KEY[0] = 1'b0;
        wait_note("c4_off", 1'b0);
        repeat (30) @(negedge DCLK);

        // One-cycle ENABLE drop
        KEY[3] = 1'b1;
        wait_note("f4_on", 1'b1);
        chk("f4_note_idx", 32'(NOTE_IDX), 32'd3);
        ENABLE = 1'b0;
        @(negedge DCLK);
        chk("disable_silence", 32'(NOTE_ON), 32'h0);
        ENABLE = 1'b1;
        @(negedge DCLK);
        chk("enable_regrant", 32'(NOTE_ON), 32'h1);
        chk("enable_regrant_idx", 32'(NOTE_IDX), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/key_tone_arbiter.md
Name: key_tone_arbiter

Overview:
- Scans the eight piano key inputs and resolves them to at most one active note at a time.
- Each key is synchronised, then debounced on a shared sample tick.
- An arbiter state machine grants the single shared tone generator to one key and drives its half-period divider value.
- Sits between the raw button pins and the tone/PWM generator.

Parameters:
- TICK_DIV, 50000, DCLK cycles per debounce sample tick (1 ms at 50 MHz); minimum 2.
- DB_TICKS, 10, consecutive equal samples required to change a debounced key state; minimum 1.
- GAP_TICKS, 20, silent ticks inserted after a note is released; minimum 1.
- CLK_HZ, 50000000, DCLK frequency used to build the note table.

Ports:
- DCLK  input  1  system clock; all state on its rising edge.
- RSTN  input  1  asynchronous active-low reset.
- KEY  input  8  raw key levels, 1 = pressed, asynchronous to DCLK; bit 0 = C4 … bit 7 = C5.
- ENABLE  input  1  synchronous enable; 0 forces silence.
- KEY_STATE  output  8  debounced key levels.
- NOTE_ON  output  1  1 while the tone generator should sound.
- NOTE_IDX  output  3  index of the granted key.
- HALF_PERIOD  output  18  DCLK cycles per half tone period for NOTE_IDX.

Behaviour:
- Reset: RSTN low asynchronously clears all state.
  - KEY_STATE=0, NOTE_ON=0, NOTE_IDX=0, HALF_PERIOD=0.
  - Prescaler = 0, debounce counters = 0, FSM = IDLE.
  - Release of reset is sampled on the next DCLK edge.
- Synchroniser: two flops per key bit; the raw KEY value is never used elsewhere.
- Prescaler: counts 0..TICK_DIV-1 and wraps. TICK is a one-cycle pulse when count = TICK_DIV-1.
- Debounce, per key, evaluated only on TICK:
  - Synced level == KEY_STATE bit: counter cleared.
  - Otherwise counter increments.
  - When the counter reaches DB_TICKS, the KEY_STATE bit toggles and the counter clears in the same edge.
  - Any bounce resets the count.
- FSM states: IDLE, PLAY, GAP.
  - IDLE: if ENABLE and KEY_STATE≠0, grant the lowest-index set bit. NOTE_IDX and HALF_PERIOD load in the same edge, NOTE_ON goes 1, and the FSM goes to PLAY. This is one DCLK of latency after KEY_STATE changes.
  - PLAY: hold the grant; other keys are ignored (no preemption). When the granted KEY_STATE bit goes 0, NOTE_ON goes 0 on that edge, the gap counter loads 0, and the FSM goes to GAP.
  - GAP: NOTE_ON=0; NOTE_IDX/HALF_PERIOD keep their last values. The gap counter increments on TICK. When it reaches GAP_TICKS, go to IDLE.
  - A key still held at the end of GAP is re-granted from IDLE (re-articulation), still lowest index first.
- ENABLE low: in any state, the FSM goes to IDLE and NOTE_ON=0 on the next edge. Debounce keeps running.
- Simultaneous presses landing on the same tick: lowest index wins.
- Granted-key release and another key press on the same tick: release wins; go to GAP.
- Note table: HALF_PERIOD = round(CLK_HZ / (2·f)), equal temperament, A4 = 440 Hz.
  - Scale C4 D4 E4 F4 G4 A4 B4 C5.
  - Check values at default CLK_HZ: A4 (idx 5) = 56818, C5 (idx 7) = 47778, C4 (idx 0) = 95556. All entries fit 18 bits.
- Counter widths are sized with clog2 of their parameter. No counter may overflow or wrap except the prescaler.

Decomposition:
- Package key_tone_pkg holds:
  - NUM_KEYS = 8.
  - State enum {IDLE, PLAY, GAP}.
  - The 18-bit note-table function/constant indexed by 3-bit note.
- Sub-module key_debounce: one key's 2-flop synchroniser, debounce counter and state. Instantiated NUM_KEYS times with a shared TICK input.
- Prescaler, priority encoder and FSM live in the top.

Test Plan:
Bench uses TICK_DIV=4, DB_TICKS=3, GAP_TICKS=2, default CLK_HZ.
1. Reset mid-PLAY with KEY[5] held → NOTE_ON, KEY_STATE, HALF_PERIOD all 0 immediately, before the next DCLK edge.
2. Clean press on KEY[5] → KEY_STATE[5] rises 2 sync + ≤3 ticks later. One DCLK later: NOTE_ON=1, NOTE_IDX=5, HALF_PERIOD=56818.
3. KEY[2] toggling every 5 DCLK for 100 cycles, then steady 1 → KEY_STATE[2] stays 0 during bouncing; rises exactly 3 ticks after bouncing stops.
4. KEY[6] and KEY[1] pressed on the same cycle → NOTE_IDX=1. Release KEY[1] while KEY[6] is held:
   - NOTE_ON=0 for 2 ticks.
   - Then NOTE_IDX=6, NOTE_ON=1.
5. KEY[7] playing, then KEY[0] pressed → NOTE_IDX remains 7 (no preemption). HALF_PERIOD remains 47778.
6. KEY[3] playing, then ENABLE dropped for 1 cycle → NOTE_ON=0 the next edge. KEY[3] is re-granted the cycle after ENABLE returns, with no GAP.
